uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: BAUD_DIV, default 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tx_data  input  8  byte to transmit; sampled only on accept.
REQ-005 parity_type  input  2  00 none, 01 odd, 10 even, 11 none; sampled only on accept.
REQ-006 tx_start  input  1  request to transmit; qualifies tx_data and parity_type.
REQ-007 tx_ready  output  1  high when a tx_start would be accepted this cycle.
REQ-008 tx  output  1  serial line, idle high, LSB first.
REQ-009 tx_busy  output  1  high while a frame is on the line.
REQ-010 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 Accept occurs when tx_start && tx_ready; tx_data and parity_type are captured into internal registers on the accepting edge.
REQ-012 tx_start while tx_ready low is ignored; no queuing, no state change.
REQ-013 FSM states are IDLE, START, DATA, PARITY and STOP; transitions are IDLE->START on accept, START->DATA, DATA->PARITY after bit 7 if parity enabled, otherwise DATA->STOP, PARITY->STOP, and STOP->IDLE.
REQ-014 tx drives the start bit (0) starting on the cycle after accept; latency from accept to the tx falling edge is 1 cycle.
REQ-015 Each bit (start, data, parity, stop) holds tx for exactly BAUD_DIV cycles, timed by a baud counter that reloads at every bit boundary.
REQ-016 Data bits go out LSB first, bit 0 through bit 7, tracked by a 3-bit index that shifts from 7 back to 0 only through a state change.
REQ-017 Parity bit = XOR of the captured 8 bits for even, and its inverse for odd; it is computed from the captured copy, never the live tx_data.
REQ-018 Parity value 00 or 11 omits the PARITY state entirely; the frame is 1 bit shorter.
REQ-019 tx_busy is high from the cycle after accept through the last stop-bit cycle inclusive; tx_ready = !tx_busy.
REQ-020 tx_done pulses high for 1 cycle on the first cycle after the last stop-bit cycle, coincident with tx_ready returning high.
REQ-021 Back-to-back operation: tx_start held high through completion is accepted in the tx_done cycle, and the next start bit follows with no idle bit.
REQ-022 Changes to tx_data or parity_type mid-frame have no effect on the frame in progress.

Reset
REQ-023 While reset is high: state=IDLE, tx=1, tx_busy=0, tx_ready=1, tx_done=0, baud counter=0, bit index=0, captured data=0x00, captured parity_type=00.
REQ-024 Reset asserted mid-frame aborts the frame immediately (asynchronously); tx returns high with no partial bit stretched.
REQ-025 A tx_start on the first clock edge after reset deassertion is accepted normally.

Configuration
REQ-026 Macro UART_TX_STOP2_EN: when defined, STOP lasts 2*BAUD_DIV cycles (two stop bits).
REQ-027 When UART_TX_STOP2_EN is undefined, STOP lasts BAUD_DIV cycles; all other behaviour is identical in both builds.

Verification (BAUD_DIV=4, macro undefined unless stated)
REQ-028 tx_data=0x55, parity 01 (odd) -> tx sequence 0,1,0,1,0,1,0,1,0,P=1,1, each held 4 cycles; tx_done pulses 44 cycles after accept.
REQ-029 tx_data=0x55, parity 10 (even) -> parity bit 0; tx_data=0x00, parity 01 -> parity bit 1; parity 11 -> 40-cycle frame with no parity bit.
REQ-030 tx_start held high with 0xA5 then 0x3C, parity 00 -> second start bit begins in the cycle after tx_done, 80 cycles total, with no idle-high gap.
REQ-031 tx_start pulsed at cycle 10 of a frame with different data -> ignored; the first frame is unchanged and no second frame is sent.
REQ-032 reset asserted at cycle 20 of a frame -> tx=1, tx_busy=0 the same cycle; no tx_done is produced.
REQ-033 UART_TX_STOP2_EN defined, 0xFF, parity 10 -> stop high for 8 cycles; tx_done 48 cycles after accept.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter, optional odd/even parity, LSB first
// Define UART_TX_STOP2_EN to send two stop bits instead of one.
module uart_tx #(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic [1:0] parity_type,
   input  logic       tx_start,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [16:0] BIT_LOAD = 17'(BAUD_DIV - 1);
`ifdef UART_TX_STOP2_EN
   localparam logic [16:0] STOP_LOAD = 17'(2 * BAUD_DIV - 1);
`else
   localparam logic [16:0] STOP_LOAD = 17'(BAUD_DIV - 1);
`endif

   logic [2:0]  state;
   logic [16:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  data_q;
   logic [1:0]  parity_q;
   logic        accept;
   logic        parity_en;
   logic        parity_bit;
   logic        bit_end;

   assign tx_busy    = (state != S_IDLE);
   assign tx_ready   = !tx_busy;
   assign accept     = tx_start && tx_ready;
   assign parity_en  = (parity_q == 2'b01) || (parity_q == 2'b10);
   assign parity_bit = (parity_q == 2'b01) ? ~^data_q : ^data_q;
   assign bit_end    = (baud_cnt == 17'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         baud_cnt <= 17'd0;
         bit_idx  <= 3'd0;
         data_q   <= 8'h00;
         parity_q <= 2'b00;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  data_q   <= tx_data;
                  parity_q <= parity_type;
                  baud_cnt <= BIT_LOAD;
                  bit_idx  <= 3'd0;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_cnt <= BIT_LOAD;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 17'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  // bit_idx wraps 7->0 only on the way out of DATA
                  if (bit_idx == 3'd7) begin
                     bit_idx  <= 3'd0;
                     state    <= parity_en ? S_PARITY : S_STOP;
                     baud_cnt <= parity_en ? BIT_LOAD : STOP_LOAD;
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     baud_cnt <= BIT_LOAD;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 17'd1;
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  baud_cnt <= STOP_LOAD;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt - 17'd1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= 17'd0;
                  tx_done  <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  baud_cnt <= baud_cnt - 17'd1;
               end
            end
            default: begin
               baud_cnt <= 17'd0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   // Line level decoded from state so reset returns tx high without waiting for a clock
   always_comb begin
      tx = 1'b1;
      case (state)
         S_START:  tx = 1'b0;
         S_DATA:   tx = data_q[bit_idx];
         S_PARITY: tx = parity_bit;
         default:  tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at BAUD_DIV=4
module tb_uart_tx;

   localparam int BAUD = 4;
`ifdef UART_TX_STOP2_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif

   typedef struct {
      logic [7:0] d;
      logic [1:0] p;
   } frame_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic [1:0] parity_type;
   logic       tx_start;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   frame_t exp_q[$];

   bit          mon_active = 1'b0;
   int          mon_cyc;
   int          mon_len;
   logic [15:0] exp_bits;
   frame_t      cur;

   uart_tx #(.BAUD_DIV(BAUD)) dut (
      .clk(clk),
      .reset(reset),
      .tx_data(tx_data),
      .parity_type(parity_type),
      .tx_start(tx_start),
      .tx_ready(tx_ready),
      .tx(tx),
      .tx_busy(tx_busy),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: pops the expected frame when the line goes busy, then checks every cycle
   always @(negedge clk) begin
      if (reset) mon_active = 1'b0;
      if (!mon_active && tx_busy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            cur.d = 8'h00;
            cur.p = 2'b00;
         end else begin
            cur = exp_q.pop_front();
         end
         exp_bits = 16'hFFFF;
         exp_bits[0] = 1'b0;
         for (int i = 0; i < 8; i++) exp_bits[i+1] = cur.d[i];
         mon_len = 9;
         if (cur.p == 2'b01) begin
            exp_bits[9] = ~^cur.d;
            mon_len = 10;
         end else if (cur.p == 2'b10) begin
            exp_bits[9] = ^cur.d;
            mon_len = 10;
         end
         mon_len = mon_len + STOP_BITS;
         mon_cyc = 0;
         mon_active = 1'b1;
      end
      if (mon_active) begin
         if (mon_cyc < mon_len * BAUD) begin
            check("frame_tx_bit", tx, exp_bits[mon_cyc / BAUD]);
            check("frame_busy", tx_busy, 1'b1);
            check("frame_no_done", tx_done, 1'b0);
         end else begin
            check("done_pulse", tx_done, 1'b1);
            check("done_busy_low", tx_busy, 1'b0);
            check("done_ready", tx_ready, 1'b1);
            check("done_tx_idle", tx, 1'b1);
            mon_active = 1'b0;
         end
         mon_cyc++;
      end else if (!tx_busy) begin
         check("idle_tx", tx, 1'b1);
         check("idle_done", tx_done, 1'b0);
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (!tx_busy && !mon_active && exp_q.size() == 0) return;
      end
      check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] p);
      frame_t f;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (tx_ready) ok = 1'b1;
      end
      if (!ok) check("send_ready_timeout", 32'd1, 32'd0);
      tx_start = 1'b1;
      tx_data = d;
      parity_type = p;
      f.d = d;
      f.p = p;
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      check("accept_tx_low", tx, 1'b0);
      check("accept_busy", tx_busy, 1'b1);
      tx_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      frame_t f;
      bit seen;
      reset = 1'b1;
      tx_start = 1'b0;
      tx_data = 8'h00;
      parity_type = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_ready", tx_ready, 1'b1);
      check("rst_done", tx_done, 1'b0);

      // start request on the first edge after reset release
      reset = 1'b0;
      tx_start = 1'b1;
      tx_data = 8'h55;
      parity_type = 2'b01;
      f.d = 8'h55;
      f.p = 2'b01;
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      check("first_edge_accept", tx_busy, 1'b1);
      tx_start = 1'b0;
      wait_idle();

      send(8'h55, 2'b10);
      wait_idle();
      send(8'h00, 2'b01);
      wait_idle();
      send(8'h55, 2'b11);
      wait_idle();
      send(8'hC3, 2'b00);
      wait_idle();

      // back-to-back with tx_start held high
      @(negedge clk);
      tx_start = 1'b1;
      tx_data = 8'hA5;
      parity_type = 2'b00;
      f.d = 8'hA5;
      f.p = 2'b00;
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      tx_data = 8'h3C;
      f.d = 8'h3C;
      exp_q.push_back(f);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (tx_done) seen = 1'b1;
      end
      check("b2b_done_seen", seen, 1'b1);
      @(negedge clk);
      #1;
      check("b2b_no_gap_tx", tx, 1'b0);
      check("b2b_no_gap_busy", tx_busy, 1'b1);
      tx_start = 1'b0;
      wait_idle();

      // start pulse mid-frame with different data must be ignored
      send(8'h55, 2'b01);
      repeat (9) @(negedge clk);
      tx_start = 1'b1;
      tx_data = 8'hAA;
      parity_type = 2'b10;
      check("ignore_ready_low", tx_ready, 1'b0);
      @(negedge clk);
      tx_start = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);
      check("ignore_no_second", tx_busy, 1'b0);

      // reset mid-frame aborts immediately
      send(8'h96, 2'b10);
      repeat (19) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_tx", tx, 1'b1);
      check("abort_busy", tx_busy, 1'b0);
      check("abort_ready", tx_ready, 1'b1);
      check("abort_done", tx_done, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("abort_queue_empty", exp_q.size(), 32'd0);

      for (int k = 0; k < 4; k++) begin
         send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
         wait_idle();
      end
`ifdef UART_TX_STOP2_EN
      send(8'hFF, 2'b10);
      wait_idle();
`endif
      repeat (5) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
